// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB, driving pc, datapath strobes and a req/ack data-memory handshake.
module seq_ctrl #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                MEM_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              is_halt,
    input  logic              is_mem,
    input  logic              wb_en,
    input  logic              is_branch,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              ir_load,
    output logic              reg_read,
    output logic              alu_enable,
    output logic              reg_write,
    output logic              mem_req,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       retire_q, retire_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_f_q, mem_f_d;
    logic              wb_f_q, wb_f_d;
    logic              br_f_q, br_f_d;
    logic              taken_q, taken_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              ir_load_q, alu_enable_q, reg_write_q, mem_req_q, halted_q, fault_q;
    logic              commit;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        retire_d = retire_q;
        cnt_d    = '0;
        mem_f_d  = mem_f_q;
        wb_f_d   = wb_f_q;
        br_f_d   = br_f_q;
        taken_d  = taken_q;
        target_d = target_q;
        commit   = 1'b0;

        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                mem_f_d = is_mem;
                wb_f_d  = wb_en;
                br_f_d  = is_branch;
                if (is_halt) begin
                    state_d  = S_HALT;
                    retire_d = retire_q + 16'd1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d  = branch_taken;
                target_d = branch_target;
                if (mem_f_q)     state_d = S_MEM;
                else if (wb_f_q) state_d = S_WB;
                else             commit  = 1'b1;
            end
            S_MEM: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    if (wb_f_q) state_d = S_WB;
                    else        commit  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    commit = 1'b1;
            default: ;
        endcase

        // taken_d/target_d already hold the live EXEC values when committing from EXEC.
        if (commit) begin
            pc_d     = (br_f_q && taken_d) ? target_d : pc_q + ADDR_W'(1);
            retire_d = retire_q + 16'd1;
            state_d  = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            retire_q     <= '0;
            cnt_q        <= '0;
            mem_f_q      <= 1'b0;
            wb_f_q       <= 1'b0;
            br_f_q       <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            ir_load_q    <= 1'b0;
            alu_enable_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            retire_q     <= retire_d;
            cnt_q        <= cnt_d;
            mem_f_q      <= mem_f_d;
            wb_f_q       <= wb_f_d;
            br_f_q       <= br_f_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            // Strobes are registered copies of the next state, so they line up with state_q.
            ir_load_q    <= (state_d == S_DECODE);
            alu_enable_q <= (state_d == S_EXEC);
            reg_write_q  <= (state_d == S_WB);
            mem_req_q    <= (state_d == S_MEM);
            halted_q     <= (state_d == S_HALT);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign pc         = pc_q;
    assign ir_load    = ir_load_q;
    assign reg_read   = ir_load_q;
    assign alu_enable = alu_enable_q;
    assign reg_write  = reg_write_q;
    assign mem_req    = mem_req_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: directed and random instructions checked against an
// instruction-level model of latency, strobe counts, pc and retire count.
module tb_seq_ctrl;

    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        is_halt = 1'b0;
    logic        is_mem = 1'b0;
    logic        wb_en = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] pc;
    logic        ir_load, reg_read, alu_enable, reg_write, mem_req, halted, fault;
    logic [2:0]  state;
    logic [15:0] retire_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] pc_m = '0;
    logic [15:0] rc_m = '0;

    seq_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .run(run), .is_halt(is_halt), .is_mem(is_mem),
        .wb_en(wb_en), .is_branch(is_branch), .branch_taken(branch_taken),
        .branch_target(branch_target), .mem_ack(mem_ack), .pc(pc), .ir_load(ir_load),
        .reg_read(reg_read), .alu_enable(alu_enable), .reg_write(reg_write),
        .mem_req(mem_req), .state(state), .halted(halted), .fault(fault),
        .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH to its end; the model works per instruction.
    task automatic do_instr(input logic mem, input logic wb, input logic br, input logic tk,
                            input logic [15:0] tgt, input int ack_k, input logic halt,
                            input logic drop);
        int   lat = 0, n_ir = 0, n_rd = 0, n_alu = 0, n_wr = 0, n_mem = 0, guard = 0;
        bit   done = 0;
        bit   exp_fault;
        int   exp_mem, exp_lat;
        logic [2:0] exp_state;
        logic [15:0] rc0;

        run = 1'b1;
        while (state !== 3'd1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("reach_fetch", state, 3'd1);

        is_mem = mem; wb_en = wb; is_branch = br; branch_taken = tk;
        branch_target = tgt; is_halt = halt; mem_ack = 1'b0;

        exp_fault = mem && !halt && (ack_k > MT);
        exp_mem   = (mem && !halt) ? ((ack_k > MT) ? MT : ack_k) : 0;
        exp_lat   = halt ? 2 : 3 + exp_mem + ((wb && !exp_fault) ? 1 : 0);
        exp_state = halt ? 3'd6 : exp_fault ? 3'd7 : (drop ? 3'd0 : 3'd1);

        rc0 = retire_cnt;
        while (!done && lat < 40) begin
            if (ir_load)    n_ir++;
            if (reg_read)   n_rd++;
            if (alu_enable) n_alu++;
            if (reg_write)  n_wr++;
            if (mem_req) begin
                n_mem++;
                mem_ack = (n_mem == ack_k);
            end else begin
                mem_ack = 1'b0;
            end
            chk("excl", (int'(ir_load) + int'(alu_enable) + int'(reg_write) + int'(mem_req)) > 1, 0);
            if (drop && alu_enable) run = 1'b0;
            lat++;
            @(negedge clk);
            if (retire_cnt !== rc0 || halted === 1'b1 || fault === 1'b1) done = 1;
        end
        mem_ack = 1'b0;

        if (!exp_fault) rc_m = rc_m + 16'd1;
        if (!exp_fault && !halt) pc_m = (br && tk) ? tgt : pc_m + 16'd1;

        chk("latency", lat, exp_lat);
        chk("n_ir_load", n_ir, 1);
        chk("n_reg_read", n_rd, 1);
        chk("n_alu", n_alu, halt ? 0 : 1);
        chk("n_reg_write", n_wr, (wb && !halt && !exp_fault) ? 1 : 0);
        chk("n_mem_req", n_mem, exp_mem);
        chk("pc", pc, pc_m);
        chk("retire", retire_cnt, rc_m);
        chk("state_after", state, exp_state);
        chk("halted", halted, halt);
        chk("fault", fault, exp_fault);
        chk("mem_req_after", mem_req, 0);
        $display("instr mem=%0d wb=%0d br=%0d tk=%0d tgt=%h ack=%0d halt=%0d drop=%0d -> lat=%0d pc=%h ret=%0d",
                 mem, wb, br, tk, tgt, ack_k, halt, drop, lat, pc, retire_cnt);

        if (drop) begin
            repeat (2) @(negedge clk);
            chk("idle_after_drop", state, 3'd0);
            run = 1'b1;
        end
    endtask

    initial begin
        int guard;
        logic m, w, b, t;
        logic [15:0] g;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_retire", retire_cnt, 16'd0);
        chk("rst_strobes", {ir_load, reg_read, alu_enable, reg_write, mem_req, halted, fault}, 7'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_run", state, 3'd0);

        // Directed instructions
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0);  // ALU with writeback
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0);  // ALU no writeback
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 1'b0, 1'b0);  // load, ack on 3rd MEM cycle
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 1, 1'b0, 1'b0);  // taken at 0x0010
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 1, 1'b0, 1'b0);
        do_instr(1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 1, 1'b0, 1'b0);  // not taken at 0x0010
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1, 1'b0, 1'b0);
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 1, 1'b0, 1'b0);  // wrap 0xFFFF -> 0
        do_instr(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, MT, 1'b0, 1'b0); // ack on final cycle
        do_instr(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b1);  // run dropped in EXEC

        // Random instructions
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            g = 16'($urandom);
            do_instr(m, w, b, t, g, int'($urandom_range(1, MT)), 1'b0,
                     $urandom_range(0, 7) == 0);
        end

        // Async reset in the middle of a MEM handshake
        run = 1'b1;
        if (pc_m == 16'h0000) do_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b0, 1'b0);
        guard = 0;
        while (state !== 3'd1 && guard < 20) begin @(negedge clk); guard++; end
        is_mem = 1'b1; wb_en = 1'b0; is_branch = 1'b0; is_halt = 1'b0; mem_ack = 1'b0;
        guard = 0;
        while (mem_req !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        chk("mid_mem_req", mem_req, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 1'b0);
        chk("async_state", state, 3'd0);
        chk("async_pc", pc, 16'h0000);
        chk("async_retire", retire_cnt, 16'd0);
        chk("async_strobes", {ir_load, reg_read, alu_enable, reg_write, halted, fault}, 6'd0);
        @(negedge clk);
        reset = 1'b1;
        pc_m = '0; rc_m = '0;

        // Halt at pc=5, then run toggling is ignored
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1, 1'b0, 1'b0);
        do_instr(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            @(negedge clk);
            chk("halt_state", state, 3'd6);
            chk("halt_pc", pc, 16'h0005);
            chk("halt_retire", retire_cnt, rc_m);
        end
        reset = 1'b0;
        #1;
        chk("halt_rst_state", state, 3'd0);
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", halted, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        pc_m = '0; rc_m = '0;

        // Memory timeout -> FAULT
        do_instr(1'b0, 1'b0, 1'b1, 1'b1, 16'h0042, 1, 1'b0, 1'b0);
        do_instr(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 99, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fault_hold", fault, 1'b1);
            chk("fault_pc", pc, 16'h0042);
            chk("fault_mem_req", mem_req, 1'b0);
        end
        reset = 1'b0;
        #1;
        chk("fault_rst_state", state, 3'd0);
        chk("fault_rst_fault", fault, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
